// File: rtl/matmul_sequencer.sv
// Control FSM for a single-MAC matrix multiply C = A x B: walks (i, j, k) row-major
// with k innermost, drives accumulator enable/load and a registered result-write strobe.
module matmul_sequencer #(
  parameter  int AROWS    = 3,
  parameter  int ACOLUMNS = 3,
  parameter  int BCOLUMNS = 3,
  localparam int IW = (AROWS    > 1) ? $clog2(AROWS)    : 1,
  localparam int KW = (ACOLUMNS > 1) ? $clog2(ACOLUMNS) : 1,
  localparam int JW = (BCOLUMNS > 1) ? $clog2(BCOLUMNS) : 1
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          start,
  input  logic          abort,
  input  logic          operand_valid,
  output logic          busy,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [KW-1:0] k,
  output logic          mac_en,
  output logic          acc_first,
  output logic          out_we,
  output logic [IW-1:0] out_row,
  output logic [JW-1:0] out_col,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic [IW-1:0] r_out_row;
  logic [JW-1:0] r_out_col;
  logic          r_out_we;
  logic          r_busy;
  logic          r_done;

  logic w_mac_en;
  logic w_i_last;
  logic w_j_last;
  logic w_k_last;

  // MAC is gated by abort so an aborted cycle can never schedule a write strobe.
  assign w_mac_en = (r_state == S_RUN) && operand_valid && !abort;
  assign w_i_last = (r_i == IW'(AROWS - 1));
  assign w_j_last = (r_j == JW'(BCOLUMNS - 1));
  assign w_k_last = (r_k == KW'(ACOLUMNS - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_out_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_out_we <= 1'b0;
      r_done   <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_i     <= '0;
        r_j     <= '0;
        r_k     <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_mac_en) begin
              if (w_k_last) begin
                r_out_we  <= 1'b1;
                r_out_row <= r_i;
                r_out_col <= r_j;
                r_k       <= '0;
                if (w_j_last) begin
                  r_j <= '0;
                  if (w_i_last) begin
                    r_i     <= '0;
                    r_state <= S_DRAIN;
                  end else begin
                    r_i <= r_i + IW'(1);
                  end
                end else begin
                  r_j <= r_j + JW'(1);
                end
              end else begin
                r_k <= r_k + KW'(1);
              end
            end
          end
          S_DRAIN: begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign i         = r_i;
  assign j         = r_j;
  assign k         = r_k;
  assign mac_en    = w_mac_en;
  assign acc_first = w_mac_en && (r_k == '0);
  assign out_we    = r_out_we;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign done      = r_done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: 3x3x3 timelines (nominal, stall, abort, held start,
// async reset) plus a 1x1x1 instance.
module tb_matmul_sequencer;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       operand_valid = 1'b0;
  logic       busy, mac_en, acc_first, out_we, done;
  logic [1:0] di, dj, dk, orow, ocol;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic       ov1 = 1'b0;
  logic       busy1, mac_en1, acc_first1, out_we1, done1;
  logic [0:0] i1, j1, k1, orow1, ocol1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  matmul_sequencer #(.AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3)) u_dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .operand_valid(operand_valid), .busy(busy), .i(di), .j(dj), .k(dk),
    .mac_en(mac_en), .acc_first(acc_first), .out_we(out_we),
    .out_row(orow), .out_col(ocol), .done(done)
  );

  matmul_sequencer #(.AROWS(1), .ACOLUMNS(1), .BCOLUMNS(1)) u_one (
    .clock(clock), .nreset(nreset), .start(start1), .abort(abort1),
    .operand_valid(ov1), .busy(busy1), .i(i1), .j(j1), .k(k1),
    .mac_en(mac_en1), .acc_first(acc_first1), .out_we(out_we1),
    .out_row(orow1), .out_col(ocol1), .done(done1)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    int writes;
    nreset = 1'b0;
    #3;
    got = {busy, mac_en, acc_first, out_we, done, di, dj, dk[0]};
    total++; if (got !== 10'd0) begin bad++; $display("FAIL reset_init got=%b exp=0", got); end
    @(negedge clock);
    nreset = 1'b1;
    next_cycle(); start = 1'b1; operand_valid = 1'b1; #1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); start = 1'b0;
    end
    #1;
    total++; if (ocol !== 2'd1) begin bad++; $display("FAIL reset_pre_col got=%0d exp=1", ocol); end
    total++; if ({di, dj, dk} !== 6'b00_10_01) begin bad++; $display("FAIL reset_pre_idx got=%b exp=001001", {di, dj, dk}); end
    #2; nreset = 1'b0; #1;
    got = {busy, mac_en, acc_first, out_we, done, di, dj, dk[0]};
    total++; if (got !== 10'd0) begin bad++; $display("FAIL reset_async got=%b exp=0", got); end
    total++; if ({dk, orow, ocol} !== 6'd0) begin bad++; $display("FAIL reset_async_addr got=%b exp=0", {dk, orow, ocol}); end
    next_cycle(); nreset = 1'b1; start = 1'b1; #1;
    writes = 0;
    for (int c = 1; c <= 30; c++) begin
      next_cycle(); start = 1'b0; #1;
      if (out_we === 1'b1) writes++;
      total++; if (done !== (c == 29)) begin bad++; $display("FAIL reset_rerun_done c=%0d got=%b exp=%b", c, done, (c == 29)); end
    end
    total++; if (writes != 9) begin bad++; $display("FAIL reset_rerun_writes got=%0d exp=9", writes); end
    total++; if ({orow, ocol} !== 4'b10_10) begin bad++; $display("FAIL reset_rerun_last got=%b exp=1010", {orow, ocol}); end
  endtask

  task automatic test_nominal();
    logic e_mac, e_first, e_we, e_busy, e_done;
    int idx, w;
    next_cycle(); start = 1'b1; operand_valid = 1'b1; #1;
    total++; if (busy !== 1'b0 || mac_en !== 1'b0) begin bad++; $display("FAIL nom_idle got=%b%b exp=00", busy, mac_en); end
    for (int c = 1; c <= 31; c++) begin
      next_cycle(); start = 1'b0; #1;
      e_mac = (c <= 27);
      e_first = e_mac && ((c - 1) % 3 == 0);
      e_we = (c >= 4) && (c <= 28) && ((c - 1) % 3 == 0);
      e_busy = (c <= 28);
      e_done = (c == 29);
      total++; if (mac_en !== e_mac) begin bad++; $display("FAIL nom_mac c=%0d got=%b exp=%b", c, mac_en, e_mac); end
      total++; if (acc_first !== e_first) begin bad++; $display("FAIL nom_first c=%0d got=%b exp=%b", c, acc_first, e_first); end
      total++; if (out_we !== e_we) begin bad++; $display("FAIL nom_we c=%0d got=%b exp=%b", c, out_we, e_we); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL nom_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (done !== e_done) begin bad++; $display("FAIL nom_done c=%0d got=%b exp=%b", c, done, e_done); end
      if (e_mac) begin
        idx = c - 1;
        total++; if ({di, dj, dk} !== {2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3)}) begin
          bad++; $display("FAIL nom_idx c=%0d got=%b exp=%0d", c, {di, dj, dk}, idx); end
      end
      if (e_we) begin
        w = (c - 4) / 3;
        total++; if ({orow, ocol} !== {2'(w / 3), 2'(w % 3)}) begin
          bad++; $display("FAIL nom_addr c=%0d got=%b exp_w=%0d", c, {orow, ocol}, w); end
      end
    end
  endtask

  task automatic test_stall();
    logic e_mac, e_we, e_busy, e_done;
    int idx, w;
    next_cycle(); start = 1'b1; operand_valid = 1'b1; #1;
    for (int c = 1; c <= 33; c++) begin
      next_cycle(); start = 1'b0; operand_valid = !(c == 5 || c == 6); #1;
      e_mac = (c <= 4) || (c >= 7 && c <= 29);
      e_we = (c == 4) || (c >= 9 && c <= 30 && (c % 3 == 0));
      e_busy = (c <= 30);
      e_done = (c == 31);
      idx = (c <= 4) ? c - 1 : (c <= 6) ? 4 : c - 3;
      total++; if (mac_en !== e_mac) begin bad++; $display("FAIL stall_mac c=%0d got=%b exp=%b", c, mac_en, e_mac); end
      total++; if (out_we !== e_we) begin bad++; $display("FAIL stall_we c=%0d got=%b exp=%b", c, out_we, e_we); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL stall_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (done !== e_done) begin bad++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, done, e_done); end
      if (c == 5 || c == 6) begin
        total++; if (acc_first !== 1'b0) begin bad++; $display("FAIL stall_first c=%0d got=%b exp=0", c, acc_first); end
      end
      if (c <= 29) begin
        total++; if ({di, dj, dk} !== {2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3)}) begin
          bad++; $display("FAIL stall_idx c=%0d got=%b exp=%0d", c, {di, dj, dk}, idx); end
      end
      if (e_we) begin
        w = (c == 4) ? 0 : (c - 6) / 3;
        total++; if ({orow, ocol} !== {2'(w / 3), 2'(w % 3)}) begin
          bad++; $display("FAIL stall_addr c=%0d got=%b exp_w=%0d", c, {orow, ocol}, w); end
      end
    end
    operand_valid = 1'b1;
  endtask

  task automatic test_abort();
    logic e_mac, e_we, e_busy, e_done;
    int idx, w;
    next_cycle(); start = 1'b1; operand_valid = 1'b1; #1;
    for (int c = 1; c <= 45; c++) begin
      next_cycle(); start = (c == 12); abort = (c == 10); #1;
      e_mac = (c <= 9) || (c >= 13 && c <= 39);
      e_we = (c == 4 || c == 7 || c == 10) || (c >= 16 && c <= 40 && (c % 3 == 1));
      e_busy = (c <= 10) || (c >= 13 && c <= 40);
      e_done = (c == 41);
      total++; if (mac_en !== e_mac) begin bad++; $display("FAIL abort_mac c=%0d got=%b exp=%b", c, mac_en, e_mac); end
      total++; if (out_we !== e_we) begin bad++; $display("FAIL abort_we c=%0d got=%b exp=%b", c, out_we, e_we); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (done !== e_done) begin bad++; $display("FAIL abort_done c=%0d got=%b exp=%b", c, done, e_done); end
      if (c == 10 || c == 11 || c == 12) begin
        idx = (c == 10) ? 9 : 0;
        total++; if ({di, dj, dk} !== {2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3)}) begin
          bad++; $display("FAIL abort_idx c=%0d got=%b exp=%0d", c, {di, dj, dk}, idx); end
      end
      if (c >= 13 && c <= 39) begin
        idx = c - 13;
        total++; if ({di, dj, dk} !== {2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3)}) begin
          bad++; $display("FAIL abort_re_idx c=%0d got=%b exp=%0d", c, {di, dj, dk}, idx); end
      end
      if (e_we) begin
        w = (c <= 10) ? (c - 4) / 3 : (c - 16) / 3;
        total++; if ({orow, ocol} !== {2'(w / 3), 2'(w % 3)}) begin
          bad++; $display("FAIL abort_addr c=%0d got=%b exp_w=%0d", c, {orow, ocol}, w); end
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_start_held();
    int idx;
    next_cycle(); start = 1'b1; operand_valid = 1'b1; #1;
    for (int c = 1; c <= 30; c++) begin
      next_cycle(); start = (c <= 28); #1;
      total++; if (done !== (c == 29)) begin bad++; $display("FAIL held_done c=%0d got=%b exp=%b", c, done, (c == 29)); end
      total++; if (busy !== (c <= 28)) begin bad++; $display("FAIL held_busy c=%0d got=%b exp=%b", c, busy, (c <= 28)); end
      if (c <= 27) begin
        idx = c - 1;
        total++; if ({di, dj, dk} !== {2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3)}) begin
          bad++; $display("FAIL held_idx c=%0d got=%b exp=%0d", c, {di, dj, dk}, idx); end
      end
    end
    next_cycle(); start = 1'b1; abort = 1'b1; #1;
    total++; if (mac_en !== 1'b0) begin bad++; $display("FAIL idle_sa_mac0 got=%b exp=0", mac_en); end
    for (int c = 0; c < 3; c++) begin
      next_cycle(); start = 1'b0; abort = 1'b0; #1;
      total++; if ({busy, mac_en, done} !== 3'b000) begin
        bad++; $display("FAIL idle_sa c=%0d got=%b exp=000", c, {busy, mac_en, done}); end
    end
  endtask

  task automatic test_one();
    next_cycle(); start1 = 1'b1; ov1 = 1'b1; #1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); start1 = 1'b0; #1;
      total++; if (mac_en1 !== (c == 1) || acc_first1 !== (c == 1)) begin
        bad++; $display("FAIL one_mac c=%0d got=%b%b exp=%b", c, mac_en1, acc_first1, (c == 1)); end
      total++; if (out_we1 !== (c == 2)) begin bad++; $display("FAIL one_we c=%0d got=%b exp=%b", c, out_we1, (c == 2)); end
      total++; if (done1 !== (c == 3)) begin bad++; $display("FAIL one_done c=%0d got=%b exp=%b", c, done1, (c == 3)); end
      total++; if (busy1 !== (c <= 2)) begin bad++; $display("FAIL one_busy c=%0d got=%b exp=%b", c, busy1, (c <= 2)); end
      total++; if ({i1, j1, k1, orow1, ocol1} !== 5'd0) begin
        bad++; $display("FAIL one_idx c=%0d got=%b exp=0", c, {i1, j1, k1, orow1, ocol1}); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    next_cycle(); next_cycle();
    test_nominal();
    next_cycle(); next_cycle();
    test_stall();
    next_cycle(); next_cycle();
    test_abort();
    next_cycle(); next_cycle();
    test_start_held();
    next_cycle();
    test_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
